// File: rtl/uart_send.sv
// rtl/uart_send.sv - UART transmitter: start, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
module uart_send #(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CNT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic          ODD_SENSE = 1'(PARITY_ODD);

  state_t          r_state;
  state_t          w_state_next;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic [7:0]      w_shift_next;
  logic            r_parity;
  logic            r_tx;
  logic            w_tx_next;
  logic            w_wrap;
  logic            w_accept;

  assign tx_ready = (r_state == S_IDLE) && !rst;
  assign w_accept = tx_valid && tx_ready;
  assign w_wrap   = (r_state != S_IDLE) && (r_cnt == LAST_CNT);
  assign tx       = r_tx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_tx     <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_shift <= w_shift_next;
      r_tx    <= w_tx_next;
      if (w_accept)
        r_parity <= (^tx_data) ^ ODD_SENSE;
      if (r_state == S_IDLE || w_wrap)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 1'b1;
      // r_bit indexes data bits in DATA and counts stop bits in STOP; it is 0 on entry to both
      if (w_wrap) begin
        if (r_state == S_DATA)
          r_bit <= r_bit + 1'b1;
        else if (r_state == S_STOP)
          r_bit <= (r_bit == LAST_STOP) ? 3'd0 : r_bit + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_next = S_START;
      S_START:  if (w_wrap) w_state_next = S_DATA;
      S_DATA:   if (w_wrap && r_bit == 3'd7)
                  w_state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (w_wrap) w_state_next = S_STOP;
      S_STOP:   if (w_wrap && r_bit == LAST_STOP) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // tx is registered, so it is computed from the state and shift value of the next cycle
  always_comb begin
    w_shift_next = r_shift;
    if (w_accept)
      w_shift_next = tx_data;
    else if (r_state == S_DATA && w_wrap)
      w_shift_next = {1'b0, r_shift[7:1]};

    w_tx_next = 1'b1;
    case (w_state_next)
      S_START:  w_tx_next = 1'b0;
      S_DATA:   w_tx_next = w_shift_next[0];
      S_PARITY: w_tx_next = r_parity;
      default:  w_tx_next = 1'b1;
    endcase

    busy = (r_state != S_IDLE);
    done = (r_state == S_STOP) && w_wrap && (r_bit == LAST_STOP) && !rst;
  end

endmodule

// File: tb/tb_uart_send.sv
// tb/tb_uart_send.sv - scoreboard bench for uart_send across five parameter sets.
module tb_uart_send;

  typedef struct {
    logic [7:0]  b;
    logic [11:0] slots;
    int          n;
    int          start;
    bit          b2b;
  } ent_t;

  logic       clk = 1'b0;
  int         cyc = 0;
  logic [4:0] rst_v;
  logic [4:0] valid_v;
  logic [4:0] ready_v;
  logic [4:0] tx_v;
  logic [4:0] busy_v;
  logic [4:0] done_v;
  logic [7:0] data_v [5];
  int         frames [5];
  int         n_checks = 0;
  int         n_err = 0;
  ent_t       q0[$], q1[$], q2[$], q3[$], q4[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_send #(.CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst_v[0]), .tx_data(data_v[0]), .tx_valid(valid_v[0]),
    .tx_ready(ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));
  uart_send #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst_v[1]), .tx_data(data_v[1]), .tx_valid(valid_v[1]),
    .tx_ready(ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));
  uart_send #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst_v[2]), .tx_data(data_v[2]), .tx_valid(valid_v[2]),
    .tx_ready(ready_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));
  uart_send #(.CLKS_PER_BIT(2), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst_v[3]), .tx_data(data_v[3]), .tx_valid(valid_v[3]),
    .tx_ready(ready_v[3]), .tx(tx_v[3]), .busy(busy_v[3]), .done(done_v[3]));
  uart_send #(.CLKS_PER_BIT(1), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u4 (
    .clk(clk), .rst(rst_v[4]), .tx_data(data_v[4]), .tx_valid(valid_v[4]),
    .tx_ready(ready_v[4]), .tx(tx_v[4]), .busy(busy_v[4]), .done(done_v[4]));

  function automatic int cpb_of(input int d);
    case (d)
      3:       return 2;
      4:       return 1;
      default: return 4;
    endcase
  endfunction

  function automatic int qsize(input int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      2:       return q2.size();
      3:       return q3.size();
      default: return q4.size();
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_e(input int d, input ent_t e);
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      2:       q2.push_back(e);
      3:       q3.push_back(e);
      default: q4.push_back(e);
    endcase
  endtask

  task automatic pop_e(input int d, output ent_t e, output bit ok);
    ok = (qsize(d) > 0);
    e = '{b: 8'h00, slots: 12'h000, n: 10, start: cyc, b2b: 1'b0};
    if (ok) begin
      case (d)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        2:       e = q2.pop_front();
        3:       e = q3.pop_front();
        default: e = q4.pop_front();
      endcase
    end
  endtask

  // slots: hand-computed line level per bit period, LSB = start bit
  task automatic send(input int d, input logic [7:0] b, input logic [11:0] slots, input int n,
                      input bit b2b, input bit hold, output int start);
    ent_t e;
    @(negedge clk);
    valid_v[d] = 1'b1;
    data_v[d]  = b;
    for (int i = 0; i < 400 && ready_v[d] !== 1'b1; i++) @(negedge clk);
    check($sformatf("u%0d_ready_wait", d), 64'(ready_v[d]), 64'd1);
    start = cyc + 1;
    e = '{b: b, slots: slots, n: n, start: start, b2b: b2b};
    push_e(d, e);
    if (!hold) begin
      @(negedge clk);
      valid_v[d] = 1'b0;
    end
  endtask

  task automatic monitor(input int d);
    int          cpb, f, prev_end, st;
    logic [63:0] got, expv, dv, dexp;
    logic [7:0]  dec;
    bit          ok_ctl, aborted, have;
    ent_t        e;
    cpb = cpb_of(d);
    prev_end = -100;
    forever begin
      @(negedge clk);
      #2;
      if (rst_v[d] || tx_v[d] !== 1'b0) continue;
      pop_e(d, e, have);
      check($sformatf("u%0d_frame_expected", d), 64'(have), 64'd1);
      f = e.n * cpb;
      st = cyc;
      got = '0; expv = '0; dv = '0; dexp = '0;
      ok_ctl = 1'b1;
      aborted = 1'b0;
      for (int k = 0; k < f; k++) begin
        if (k > 0) begin
          @(negedge clk);
          #2;
        end
        if (rst_v[d]) begin
          aborted = 1'b1;
          break;
        end
        got[k]  = tx_v[d];
        dv[k]   = done_v[d];
        expv[k] = e.slots[k / cpb];
        if (busy_v[d] !== 1'b1 || ready_v[d] !== 1'b0) ok_ctl = 1'b0;
      end
      if (aborted) begin
        check($sformatf("u%0d_abort_no_done", d), dv, 64'd0);
        continue;
      end
      dexp[f-1] = 1'b1;
      for (int i = 0; i < 8; i++) dec[i] = got[cpb * (i + 1) + cpb / 2];
      check($sformatf("u%0d_latency", d), 64'(st), 64'(e.start));
      check($sformatf("u%0d_bits_%0h", d, e.b), got, expv);
      check($sformatf("u%0d_done_%0h", d, e.b), dv, dexp);
      check($sformatf("u%0d_busy_ready", d), 64'(ok_ctl), 64'd1);
      check($sformatf("u%0d_decode", d), 64'(dec), 64'(e.b));
      if (e.b2b) check($sformatf("u%0d_gap", d), 64'(st), 64'(prev_end + 2));
      prev_end = cyc;
      frames[d]++;
      @(negedge clk);
      #2;
      if (!rst_v[d]) check($sformatf("u%0d_idle_gap", d), 64'({tx_v[d], ready_v[d]}), 64'd3);
    end
  endtask

  initial begin
    int s;
    rst_v   = 5'h1f;
    valid_v = 5'h00;
    for (int i = 0; i < 5; i++) begin
      data_v[i] = 8'h00;
      frames[i] = 0;
    end
    fork
      monitor(0);
      monitor(1);
      monitor(2);
      monitor(3);
      monitor(4);
    join_none
    repeat (3) @(negedge clk);
    check("reset_tx", 64'(tx_v), 64'h1f);
    check("reset_busy", 64'(busy_v), 64'h00);
    check("reset_done", 64'(done_v), 64'h00);
    check("reset_ready_in_rst", 64'(ready_v), 64'h00);
    rst_v = 5'h00;
    #1;
    check("reset_ready", 64'(ready_v), 64'h1f);

    fork
      begin
        send(0, 8'h55, 12'b1010101010, 10, 1'b0, 1'b0, s);
        send(0, 8'hC3, 12'b1110000110, 10, 1'b0, 1'b0, s);
        for (int i = 0; i < 30; i++) begin
          @(negedge clk);
          valid_v[0] = i[0];
          data_v[0]  = 8'h00;
        end
        send(0, 8'h00, 12'b1000000000, 10, 1'b0, 1'b0, s);
        send(0, 8'hFF, 12'b1111111110, 10, 1'b0, 1'b0, s);
        while (cyc < s + 16) @(negedge clk);
        rst_v[0] = 1'b1;
        @(negedge clk);
        rst_v[0] = 1'b0;
        #1;
        check("abort_tx", 64'(tx_v[0]), 64'd1);
        check("abort_ready", 64'(ready_v[0]), 64'd1);
        check("abort_busy", 64'(busy_v[0]), 64'd0);
        check("abort_done", 64'(done_v[0]), 64'd0);
        send(0, 8'h81, 12'b1100000010, 10, 1'b0, 1'b0, s);
      end
      begin
        send(1, 8'h07, 12'b11000001110, 11, 1'b0, 1'b0, s);
      end
      begin
        send(2, 8'h07, 12'b10000001110, 11, 1'b0, 1'b0, s);
      end
      begin
        send(3, 8'hA5, 12'b11101001010, 11, 1'b0, 1'b1, s);
        send(3, 8'h3C, 12'b11001111000, 11, 1'b1, 1'b0, s);
      end
      begin
        send(4, 8'h96, 12'b1100101100, 10, 1'b0, 1'b0, s);
      end
    join

    repeat (80) @(negedge clk);
    for (int d = 0; d < 5; d++)
      check($sformatf("u%0d_queue_drained", d), 64'(qsize(d)), 64'd0);
    check("u0_frames", 64'(frames[0]), 64'd4);
    check("u1_frames", 64'(frames[1]), 64'd1);
    check("u2_frames", 64'(frames[2]), 64'd1);
    check("u3_frames", 64'(frames[3]), 64'd2);
    check("u4_frames", 64'(frames[4]), 64'd1);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
